// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter that funnels many level-sensitive requesters onto one
// req/ack upstream producer and returns the fetched word with a one-cycle ack.
module handshake_rr_arbiter #(
    parameter int num_ports  = 4,
    parameter int data_width = 32,
    parameter int timeout    = 0,
    localparam int gw = (num_ports > 1) ? $clog2(num_ports) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [num_ports-1:0]  req_in,
    output logic [num_ports-1:0]  ack_out,
    output logic [data_width-1:0] dout,
    output logic                  req_up,
    input  logic                  ack_up,
    input  logic [data_width-1:0] din_up,
    output logic [gw-1:0]         grant_id,
    output logic                  busy,
    output logic                  err,
    output logic [31:0]           count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [gw-1:0]           ptr_reg;
    logic [gw-1:0]           grant_reg;
    logic [gw-1:0]           ptr_next;
    logic                    req_up_reg;
    logic [num_ports-1:0]    ack_out_reg;
    logic [data_width-1:0]   dout_reg;
    logic                    err_reg;
    logic [31:0]             count_reg;
    logic [31:0]             wait_reg;
    logic                    wait_expire;

    logic [gw-1:0]           cand_idx [num_ports];
    logic [num_ports-1:0]    cand_vld;
    logic [num_ports-1:0]    grant_onehot;
    logic [gw-1:0]           pick_idx;

    genvar gi;

    // Candidate gi is the requester gi positions after ptr, wrapping at num_ports.
    generate
        for (gi = 0; gi < num_ports; gi++) begin : g_rot
            logic [gw:0] sum;
            assign sum           = {1'b0, ptr_reg} + (gw+1)'(gi);
            assign cand_idx[gi]  = (sum >= (gw+1)'(num_ports))
                                   ? gw'(sum - (gw+1)'(num_ports))
                                   : sum[gw-1:0];
            assign cand_vld[gi]  = req_in[cand_idx[gi]];
            assign grant_onehot[gi] = (grant_reg == gw'(gi));
        end
    endgenerate

    always_comb begin
        pick_idx = '0;
        for (int i = num_ports - 1; i >= 0; i--) begin
            if (cand_vld[i]) begin
                pick_idx = cand_idx[i];
            end
        end
    end

    assign ptr_next    = (grant_reg == gw'(num_ports - 1)) ? '0 : grant_reg + 1'b1;
    // Abort on the edge that would make the count reach the limit; an ack on that edge wins.
    assign wait_expire = (timeout > 0) && (wait_reg == 32'(timeout - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (|req_in) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ack_up) begin
                    state_next = RESP;
                end else if (wait_expire) begin
                    state_next = IDLE;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_reg     <= '0;
            grant_reg   <= '0;
            req_up_reg  <= 1'b0;
            ack_out_reg <= '0;
            dout_reg    <= '0;
            err_reg     <= 1'b0;
            count_reg   <= '0;
            wait_reg    <= '0;
        end else begin
            ack_out_reg <= '0;
            err_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|req_in) begin
                        grant_reg  <= pick_idx;
                        req_up_reg <= 1'b1;
                        wait_reg   <= '0;
                    end
                end
                REQ: begin
                    if (ack_up) begin
                        req_up_reg  <= 1'b0;
                        dout_reg    <= din_up;
                        ack_out_reg <= grant_onehot;
                        count_reg   <= count_reg + 32'd1;
                        ptr_reg     <= ptr_next;
                    end else if (wait_expire) begin
                        req_up_reg <= 1'b0;
                        err_reg    <= 1'b1;
                        ptr_reg    <= ptr_next;
                    end else begin
                        wait_reg <= wait_reg + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack_out  = ack_out_reg;
    assign dout     = dout_reg;
    assign req_up   = req_up_reg;
    assign grant_id = grant_reg;
    assign err      = err_reg;
    assign count    = count_reg;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Bench for handshake_rr_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level round-robin model.
module tb_handshake_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int TO = 5;

    logic          clk;
    logic          rst;
    logic [NP-1:0] req_in;
    logic [NP-1:0] ack_out;
    logic [DW-1:0] dout;
    logic          req_up;
    logic          ack_up;
    logic [DW-1:0] din_up;
    logic [1:0]    grant_id;
    logic          busy;
    logic          err;
    logic [31:0]   count;

    int n_checks = 0;
    int n_fail   = 0;

    handshake_rr_arbiter #(
        .num_ports(NP),
        .data_width(DW),
        .timeout(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_in(req_in),
        .ack_out(ack_out),
        .dout(dout),
        .req_up(req_up),
        .ack_up(ack_up),
        .din_up(din_up),
        .grant_id(grant_id),
        .busy(busy),
        .err(err),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requesting index at or after p, wrapping.
    function automatic int rr_pick(int p, logic [NP-1:0] r);
        for (int i = 0; i < NP; i++) begin
            if (r[(p + i) % NP]) return (p + i) % NP;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b0; req_in = '1; ack_up = 1'b1; din_up = 32'hFFFF_FFFF;
        step(); step();
        n_checks++;
        if ({req_up, ack_out, busy, err} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 0000000", {req_up, ack_out, busy, err});
        end
        n_checks++;
        if (dout !== 32'd0 || count !== 32'd0 || grant_id !== 2'd0) begin
            n_fail++; $display("FAIL reset_data: got dout=%0h count=%0d grant=%0d required 0/0/0", dout, count, grant_id);
        end
        rst = 1'b1; req_in = '0; ack_up = 1'b0; din_up = '0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_single();
        req_in = 4'b0010;
        step();
        n_checks++;
        if (req_up !== 1'b1 || grant_id !== 2'd1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_grant: got req_up=%b grant=%0d busy=%b required 1/1/1", req_up, grant_id, busy);
        end
        req_in = 4'b0000;
        step();
        n_checks++;
        if (req_up !== 1'b1 || ack_out !== 4'b0000) begin
            n_fail++; $display("FAIL single_wait: got req_up=%b ack_out=%b required 1/0000", req_up, ack_out);
        end
        ack_up = 1'b1; din_up = 32'h5;
        step();
        n_checks++;
        if (ack_out !== 4'b0010 || dout !== 32'h5 || count !== 32'd1 || req_up !== 1'b0) begin
            n_fail++; $display("FAIL single_ack: got ack_out=%b dout=%0h count=%0d req_up=%b required 0010/5/1/0", ack_out, dout, count, req_up);
        end
        ack_up = 1'b0; din_up = '0;
        step();
        n_checks++;
        if (ack_out !== 4'b0000 || busy !== 1'b0 || dout !== 32'h5) begin
            n_fail++; $display("FAIL single_resp: got ack_out=%b busy=%b dout=%0h required 0000/0/5", ack_out, busy, dout);
        end
        $display("test_single done: grant=%0d count=%0d", grant_id, count);
    endtask

    task automatic test_all_requesting();
        rst = 1'b0; step(); rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_in = 4'b1111;
            step();
            n_checks++;
            if (int'(grant_id) !== k % NP) begin
                n_fail++; $display("FAIL rotate_grant: got %0d required %0d", grant_id, k % NP);
            end
            ack_up = 1'b1; din_up = 32'(100 + k);
            step();
            n_checks++;
            if (ack_out !== 4'(1 << (k % NP)) || dout !== 32'(100 + k)) begin
                n_fail++; $display("FAIL rotate_ack: got ack_out=%b dout=%0d required %b/%0d", ack_out, dout, 4'(1 << (k % NP)), 100 + k);
            end
            ack_up = 1'b0;
            step();
            $display("rotate xfer %0d: grant=%0d", k, k % NP);
        end
        req_in = '0;
        n_checks++;
        if (count !== 32'd8) begin
            n_fail++; $display("FAIL rotate_count: got %0d required 8", count);
        end
    endtask

    task automatic test_pointer_skip();
        int exp_g [3] = '{2, 0, 1};
        logic [NP-1:0] reqs [3] = '{4'b0100, 4'b0011, 4'b0011};
        for (int k = 0; k < 3; k++) begin
            req_in = reqs[k];
            step();
            n_checks++;
            if (int'(grant_id) !== exp_g[k]) begin
                n_fail++; $display("FAIL skip_grant: got %0d required %0d", grant_id, exp_g[k]);
            end
            ack_up = 1'b1; din_up = 32'(k);
            step();
            ack_up = 1'b0;
            step();
            $display("skip xfer %0d: grant=%0d", k, exp_g[k]);
        end
        req_in = '0;
        n_checks++;
        if (count !== 32'd11) begin
            n_fail++; $display("FAIL skip_count: got %0d required 11", count);
        end
    endtask

    task automatic test_timeout();
        req_in = 4'b0001;
        step();
        req_in = 4'b0000;
        n_checks++;
        if (req_up !== 1'b1 || grant_id !== 2'd0) begin
            n_fail++; $display("FAIL to_start: got req_up=%b grant=%0d required 1/0", req_up, grant_id);
        end
        for (int i = 1; i < TO; i++) begin
            step();
            n_checks++;
            if (req_up !== 1'b1 || err !== 1'b0) begin
                n_fail++; $display("FAIL to_hold: got req_up=%b err=%b required 1/0 at cycle %0d", req_up, err, i);
            end
        end
        step();
        n_checks++;
        if (req_up !== 1'b0 || err !== 1'b1 || ack_out !== 4'b0 || count !== 32'd11 || busy !== 1'b0) begin
            n_fail++; $display("FAIL to_abort: got req_up=%b err=%b ack_out=%b count=%0d busy=%b required 0/1/0000/11/0",
                               req_up, err, ack_out, count, busy);
        end
        req_in = 4'b0011;
        step();
        n_checks++;
        if (err !== 1'b0 || grant_id !== 2'd1) begin
            n_fail++; $display("FAIL to_after: got err=%b grant=%0d required 0/1", err, grant_id);
        end
        req_in = 4'b0000;
        for (int i = 1; i < TO; i++) step();
        ack_up = 1'b1; din_up = 32'hA5;
        step();
        n_checks++;
        if (ack_out !== 4'b0010 || err !== 1'b0 || count !== 32'd12 || dout !== 32'hA5) begin
            n_fail++; $display("FAIL to_ack_wins: got ack_out=%b err=%b count=%0d dout=%0h required 0010/0/12/a5",
                               ack_out, err, count, dout);
        end
        ack_up = 1'b0;
        step();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0 || ack_out !== 4'b0) begin
            n_fail++; $display("FAIL to_ack_resp: got err=%b busy=%b ack_out=%b required 0/0/0000", err, busy, ack_out);
        end
        $display("test_timeout done: count=%0d", count);
    endtask

    task automatic test_reset_mid();
        req_in = 4'b1000;
        step();
        req_in = 4'b0000;
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_checks++;
        if ({req_up, ack_out, busy, err} !== 7'b0 || dout !== 32'd0 || count !== 32'd0 || grant_id !== 2'd0) begin
            n_fail++; $display("FAIL midrst_state: got ctrl=%b dout=%0h count=%0d grant=%0d required 0", {req_up, ack_out, busy, err}, dout, count, grant_id);
        end
        ack_up = 1'b1; din_up = 32'hDEAD;
        step();
        ack_up = 1'b0;
        n_checks++;
        if (ack_out !== 4'b0 || count !== 32'd0 || dout !== 32'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_late_ack: got ack_out=%b count=%0d dout=%0h busy=%b required 0000/0/0/0", ack_out, count, dout, busy);
        end
        step();
        $display("test_reset_mid done: count=%0d", count);
    endtask

    task automatic test_stress();
        int ptr, cnt, win, waited, steps, done_n, obs_total, n_to;
        logic [NP-1:0] r;
        logic [31:0] seq, last_dout;
        logic [31:0] last_rx [NP];
        int obs_pulse [NP];
        logic ack;
        bit finished;
        rst = 1'b0; req_in = '0; ack_up = 1'b0; step(); rst = 1'b1;
        ptr = 0; cnt = 0; seq = 32'd1; last_dout = '0; steps = 0; done_n = 0; n_to = 0;
        for (int i = 0; i < NP; i++) begin last_rx[i] = '0; obs_pulse[i] = 0; end
        while (done_n < 5000) begin
            if (steps > 60000) begin
                n_checks++; n_fail++;
                $display("FAIL stress_budget: got %0d cycles, required completion under 60000", steps);
                break;
            end
            for (int i = 0; i < NP; i++) r[i] = ($urandom_range(0, 99) < 70);
            req_in = r; ack_up = ($urandom_range(0, 99) < 30); din_up = $urandom;
            step(); steps++;
            for (int i = 0; i < NP; i++) obs_pulse[i] += int'(ack_out[i]);
            if (r == '0) begin
                n_checks++;
                if (busy !== 1'b0 || req_up !== 1'b0 || count !== cnt || dout !== last_dout) begin
                    n_fail++; $display("FAIL stress_idle: got busy=%b req_up=%b count=%0d dout=%0h required 0/0/%0d/%0h", busy, req_up, count, dout, cnt, last_dout);
                end
                continue;
            end
            win = rr_pick(ptr, r);
            n_checks++;
            if (int'(grant_id) !== win || req_up !== 1'b1 || err !== 1'b0) begin
                n_fail++; $display("FAIL stress_grant: got grant=%0d req_up=%b err=%b required %0d/1/0 (req=%b)", grant_id, req_up, err, win, r);
            end
            waited = 0; finished = 0;
            while (!finished) begin
                for (int i = 0; i < NP; i++) req_in[i] = ($urandom_range(0, 99) < 70);
                ack = ($urandom_range(0, 99) < 70);
                ack_up = ack; din_up = ack ? seq : $urandom;
                step(); steps++;
                for (int i = 0; i < NP; i++) obs_pulse[i] += int'(ack_out[i]);
                if (ack) begin
                    cnt++;
                    n_checks++;
                    if (ack_out !== 4'(1 << win) || dout !== seq || count !== cnt) begin
                        n_fail++; $display("FAIL stress_ack: got ack_out=%b dout=%0h count=%0d required %b/%0h/%0d", ack_out, dout, count, 4'(1 << win), seq, cnt);
                    end
                    n_checks++;
                    if (dout <= last_rx[win]) begin
                        n_fail++; $display("FAIL stress_order: got %0h for requester %0d, required above %0h", dout, win, last_rx[win]);
                    end
                    last_rx[win] = seq; last_dout = seq; seq++;
                    ptr = (win + 1) % NP; done_n++; finished = 1;
                    for (int i = 0; i < NP; i++) req_in[i] = ($urandom_range(0, 99) < 70);
                    ack_up = ($urandom_range(0, 99) < 30); din_up = $urandom;
                    step(); steps++;
                    for (int i = 0; i < NP; i++) obs_pulse[i] += int'(ack_out[i]);
                    n_checks++;
                    if (ack_out !== 4'b0 || busy !== 1'b0 || dout !== last_dout || count !== cnt) begin
                        n_fail++; $display("FAIL stress_resp: got ack_out=%b busy=%b dout=%0h count=%0d required 0000/0/%0h/%0d", ack_out, busy, dout, count, last_dout, cnt);
                    end
                end else begin
                    waited++;
                    n_checks++;
                    if (waited == TO) begin
                        if (err !== 1'b1 || req_up !== 1'b0 || ack_out !== 4'b0 || count !== cnt) begin
                            n_fail++; $display("FAIL stress_timeout: got err=%b req_up=%b ack_out=%b count=%0d required 1/0/0000/%0d", err, req_up, ack_out, count, cnt);
                        end
                        ptr = (win + 1) % NP; finished = 1; n_to++;
                    end else if (req_up !== 1'b1 || err !== 1'b0 || ack_out !== 4'b0) begin
                        n_fail++; $display("FAIL stress_wait: got req_up=%b err=%b ack_out=%b required 1/0/0000", req_up, err, ack_out);
                    end
                end
            end
        end
        req_in = '0; ack_up = 1'b0;
        step();
        obs_total = 0;
        for (int i = 0; i < NP; i++) obs_total += obs_pulse[i];
        n_checks++;
        if (count !== 32'(obs_total) || count !== 32'(cnt)) begin
            n_fail++; $display("FAIL stress_total: got count=%0d pulses=%0d required %0d", count, obs_total, cnt);
        end
        $display("test_stress done: transfers=%0d timeouts=%0d pulses=%0d/%0d/%0d/%0d",
                 cnt, n_to, obs_pulse[0], obs_pulse[1], obs_pulse[2], obs_pulse[3]);
    endtask

    initial begin
        rst = 1'b0; req_in = '0; ack_up = 1'b0; din_up = '0;
        test_reset();
        test_single();
        test_all_requesting();
        test_pointer_skip();
        test_timeout();
        test_reset_mid();
        test_stress();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
